// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: pipeline inputs, forwarding sources and stage results.
// Latency: none, signal container only.
// Backpressure: stall travels back to the front of the pipeline through this bundle.
//
// Ports (master = pipeline/hazard side, slave = ex_stage):
//   EX[3:0]          RegDst, ALUOp[1:0], ALUSrc from ID/EX
//   rs, rt, rd       register numbers from ID/EX
//   cpPlus4, data1, data2, immediate (sign-extended) from ID/EX
//   exMemRegWrite/exMemRd/exMemResult, memWbRegWrite/memWbRd/memWbData  forwarding sources
//   aluResult, writeData, writeReg, zero, branchTarget, stall             stage results
interface ex_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            EX;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] cpPlus4;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [DATA_WIDTH-1:0] immediate;
    logic                  exMemRegWrite;
    logic [4:0]            exMemRd;
    logic [DATA_WIDTH-1:0] exMemResult;
    logic                  memWbRegWrite;
    logic [4:0]            memWbRd;
    logic [DATA_WIDTH-1:0] memWbData;
    logic [DATA_WIDTH-1:0] aluResult;
    logic [DATA_WIDTH-1:0] writeData;
    logic [4:0]            writeReg;
    logic                  zero;
    logic [DATA_WIDTH-1:0] branchTarget;
    logic                  stall;

    modport master (
        output EX, rs, rt, rd, cpPlus4, data1, data2, immediate,
        output exMemRegWrite, exMemRd, exMemResult,
        output memWbRegWrite, memWbRd, memWbData,
        input  aluResult, writeData, writeReg, zero, branchTarget, stall
    );

    modport slave (
        input  EX, rs, rt, rd, cpPlus4, data1, data2, immediate,
        input  exMemRegWrite, exMemRd, exMemResult,
        input  memWbRegWrite, memWbRd, memWbData,
        output aluResult, writeData, writeReg, zero, branchTarget, stall
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, dest-reg select, branch adder, iterative mul/div with HI/LO.
// Latency: ALU/forwarding/branch paths combinational; mult/div holds the front end for 33 cycles, retires on the 34th.
// Backpressure: stall is high in the mul/div detect cycle and all 32 BUSY cycles; low otherwise and during reset.
//
// Ports:
//   clock  pipeline clock, rising edge
//   reset  asynchronous, active-high; aborts any mul/div in flight and clears HI/LO
//   bus    ex_stage_if.slave carrying the ID/EX inputs, forwarding sources and EX/MEM-bound results
module ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] LAST_STEP = 5'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_reg_dst;
    logic [1:0] w_alu_op;
    logic       w_alu_src;
    logic [5:0] w_funct;
    logic [4:0] w_shamt;

    assign {w_reg_dst, w_alu_op, w_alu_src} = bus.EX;
    assign w_funct = bus.immediate[5:0];
    assign w_shamt = bus.immediate[10:6];

    // ------------------------------------------------------------------
    // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded
    // ------------------------------------------------------------------
    logic                  w_exmem_a;
    logic                  w_exmem_b;
    logic                  w_memwb_a;
    logic                  w_memwb_b;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;
    logic [DATA_WIDTH-1:0] w_alu_b;

    assign w_exmem_a = bus.exMemRegWrite && (bus.exMemRd != 5'd0) && (bus.exMemRd == bus.rs);
    assign w_exmem_b = bus.exMemRegWrite && (bus.exMemRd != 5'd0) && (bus.exMemRd == bus.rt);
    assign w_memwb_a = bus.memWbRegWrite && (bus.memWbRd != 5'd0) && (bus.memWbRd == bus.rs);
    assign w_memwb_b = bus.memWbRegWrite && (bus.memWbRd != 5'd0) && (bus.memWbRd == bus.rt);

    assign w_fwd_a = w_exmem_a ? bus.exMemResult :
                     w_memwb_a ? bus.memWbData   : bus.data1;
    assign w_fwd_b = w_exmem_b ? bus.exMemResult :
                     w_memwb_b ? bus.memWbData   : bus.data2;

    assign w_alu_b = w_alu_src ? bus.immediate : w_fwd_b;

    // ------------------------------------------------------------------
    // Mul/div unit state
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [4:0]              r_cnt;
    // Mult: {partial product hi, multiplier/product lo}. Div: {remainder, dividend/quotient}.
    logic [2*DATA_WIDTH-1:0] r_p;
    logic [DATA_WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
    logic                    r_is_div;
    logic                    r_neg_main;  // negate product / quotient
    logic                    r_neg_rem;   // negate remainder
    logic                    r_div_zero;
    logic [DATA_WIDTH-1:0]   r_dividend;  // original dividend, reported as HI on divide by zero
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;

    // funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
    logic                  w_md_start;
    logic                  w_md_div;
    logic                  w_md_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;

    assign w_md_start  = (w_alu_op == 2'b10) && (w_funct[5:2] == 4'b0110);
    assign w_md_div    = w_funct[1];
    assign w_md_signed = ~w_funct[0];
    assign w_a_neg     = w_md_signed & w_fwd_a[DATA_WIDTH-1];
    assign w_b_neg     = w_md_signed & w_fwd_b[DATA_WIDTH-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_mag_a     = w_a_neg ? ('0 - w_fwd_a) : w_fwd_a;
    assign w_mag_b     = w_b_neg ? ('0 - w_fwd_b) : w_fwd_b;

    // Shift-add step: conditionally add multiplicand into the upper half, then shift right
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_p[2*DATA_WIDTH-1:DATA_WIDTH]} +
                        (r_p[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_p[DATA_WIDTH-1:1]};

    // Restoring divide step: shift left one dividend bit into the remainder, try subtracting
    logic [DATA_WIDTH:0]     w_div_shift;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic [2*DATA_WIDTH-1:0] w_div_next;

    assign w_div_shift = r_p[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[DATA_WIDTH] ?
                         {w_div_shift[DATA_WIDTH-1:0], r_p[DATA_WIDTH-2:0], 1'b0} :
                         {w_div_diff[DATA_WIDTH-1:0],  r_p[DATA_WIDTH-2:0], 1'b1};

    // Sign fix-up of the finished magnitudes
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_hi_new;
    logic [DATA_WIDTH-1:0]   w_lo_new;

    assign w_prod = r_neg_main ? ('0 - r_p) : r_p;
    assign w_quo  = r_neg_main ? ('0 - r_p[DATA_WIDTH-1:0]) : r_p[DATA_WIDTH-1:0];
    assign w_rem  = r_neg_rem  ? ('0 - r_p[2*DATA_WIDTH-1:DATA_WIDTH]) :
                                 r_p[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_hi_new = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        w_lo_new = w_prod[DATA_WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_hi_new = r_dividend;
                w_lo_new = '1;
            end else begin
                w_hi_new = w_rem;
                w_lo_new = w_quo;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_p        <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_start) begin
                        r_state    <= ST_BUSY;
                        r_cnt      <= 5'd0;
                        r_p        <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                        r_opnd     <= w_mag_b;
                        r_is_div   <= w_md_div;
                        r_neg_main <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= w_md_div && (w_fwd_b == '0);
                        r_dividend <= w_fwd_a;
                    end
                end
                ST_BUSY: begin
                    r_p   <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_DONE;
                    end
                end
                // Unconditional return to IDLE: the retiring instruction is still
                // in EX this cycle and must not be seen as a fresh start.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_DONE) begin
            r_hi <= w_hi_new;
            r_lo <= w_lo_new;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] w_sra;
    logic [DATA_WIDTH-1:0]        w_alu;

    assign w_sra = $signed(w_alu_b) >>> w_shamt;

    always_comb begin
        w_alu = '0;
        case (w_alu_op)
            2'b00: w_alu = w_fwd_a + w_alu_b;
            2'b01: w_alu = w_fwd_a - w_alu_b;
            2'b11: w_alu = w_fwd_a | {{(DATA_WIDTH-16){1'b0}}, bus.immediate[15:0]};
            default: begin
                // R-type; mul/div functs and undefined functs fall to zero
                case (w_funct)
                    6'h20, 6'h21: w_alu = w_fwd_a + w_alu_b;
                    6'h22, 6'h23: w_alu = w_fwd_a - w_alu_b;
                    6'h24:        w_alu = w_fwd_a & w_alu_b;
                    6'h25:        w_alu = w_fwd_a | w_alu_b;
                    6'h26:        w_alu = w_fwd_a ^ w_alu_b;
                    6'h27:        w_alu = ~(w_fwd_a | w_alu_b);
                    6'h2A:        w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_b))};
                    6'h2B:        w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_fwd_a < w_alu_b)};
                    6'h00:        w_alu = w_alu_b << w_shamt;
                    6'h02:        w_alu = w_alu_b >> w_shamt;
                    6'h03:        w_alu = w_sra;
                    6'h10:        w_alu = r_hi;
                    6'h12:        w_alu = r_lo;
                    default:      w_alu = '0;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.aluResult    = w_alu;
    assign bus.writeData    = w_fwd_b;
    assign bus.writeReg     = w_reg_dst ? bus.rd : bus.rt;
    assign bus.zero         = (w_alu == '0);
    assign bus.branchTarget = bus.cpPlus4 + {bus.immediate[DATA_WIDTH-3:0], 2'b00};
    // Gated by reset so an aborted mul/div still sitting in EX cannot re-stall until reset lifts
    assign bus.stall        = ~reset &
                              (((r_state == ST_IDLE) && w_md_start) || (r_state == ST_BUSY));

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the five-stage pipeline. Consumes the ID/EX pipeline register outputs and produces the values captured by the EX/MEM register.
- Contains the operand forwarding muxes, the ALU, destination-register select and branch-target adder.
- Contains an iterative 32-cycle multiply/divide unit with architectural HI/LO registers; it stalls the front of the pipeline while busy.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported; the mul/div iteration count equals DATA_WIDTH.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- EX  in  4  from ID/EX: [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
- rs, rt, rd  in  5 each  register numbers from ID/EX
- cpPlus4, data1, data2, immediate  in  32 each  from ID/EX; immediate is sign-extended
- exMemRegWrite  in  1  EX/MEM write enable
- exMemRd  in  5  EX/MEM destination register
- exMemResult  in  32  EX/MEM result
- memWbRegWrite  in  1  MEM/WB write enable
- memWbRd  in  5  MEM/WB destination register
- memWbData  in  32  MEM/WB write-back value
- aluResult  out  32  ALU or mfhi/mflo result
- writeData  out  32  forwarded rt value, used as store data
- writeReg  out  5  destination register: rd if RegDst, else rt
- zero  out  1  aluResult == 0
- branchTarget  out  32  cpPlus4 + (immediate << 2), wraps modulo 2^32
- stall  out  1  when high: hold PC, IF/ID and ID/EX; load a bubble into EX/MEM

Behaviour:
- Forwarding, operand A (rs) and B (rt), each independent:
  - Select exMemResult if exMemRegWrite and exMemRd != 0 and exMemRd == rs/rt.
  - Otherwise select memWbData if memWbRegWrite and memWbRd != 0 and it matches.
  - Otherwise select data1/data2.
  - EX/MEM has priority over MEM/WB.
- writeData is forwarded operand B.
- ALU input B is the immediate if ALUSrc, else forwarded operand B.
- ALUOp decode:
  - 00: add.
  - 01: sub.
  - 11: OR with zero-extended immediate[15:0].
  - 10: R-type, decoded by funct = immediate[5:0]:
    - 0x20/0x21 add, 0x22/0x23 sub: no overflow trap, wrap modulo 2^32.
    - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
    - 0x2A slt (signed), 0x2B sltu: result 1 or 0.
    - 0x00 sll, 0x02 srl, 0x03 sra: shift operand B by shamt = immediate[10:6].
    - 0x10 mfhi, 0x12 mflo: result is HI/LO.
    - Undefined funct: result 0.
- The ALU, forwarding, writeReg, zero and branchTarget paths are combinational. The only state is the mul/div FSM, its counter and datapath, and HI/LO.
- Mul/div start condition: ALUOp==10 and funct in {0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}.
- Mul/div FSM states IDLE, BUSY, DONE:
  - IDLE: on the start condition, stall=1 combinationally in that cycle. Capture the forwarded operands and op type, clear the counter, go to BUSY.
  - BUSY: one shift-add (mult) or restoring shift-subtract (div) step per cycle; stall=1. After step 32 (counter==31), go to DONE.
  - DONE: write HI/LO at the end of this cycle; stall=0 so the instruction retires. Always go to IDLE next, so the same instruction does not restart.
- Timing: the detect cycle plus 32 BUSY cycles give stall=1 for exactly 33 cycles. An mfhi/mflo in the following instruction reads the new HI/LO.
- aluResult for the mul/div instruction itself is 0. Its writeReg is irrelevant because the instruction has no register write.
- Signed ops run on operand magnitudes. Negate the product if the operand signs differ. Quotient takes sign(a)^sign(b); remainder takes sign(a).
- Results: mult/multu write HI=product[63:32], LO=product[31:0]. div/divu write LO=quotient, HI=remainder.
- Divide by zero (both div and divu): LO=0xFFFFFFFF, HI=dividend. Takes the full 33 cycles.
- 0x80000000 div -1: LO=0x80000000, HI=0.
- Reset is asynchronous at any time, including mid-BUSY: state=IDLE, counter=0, HI=LO=0, stall=0. The partial result is discarded and HI/LO are not written.

Test Plan:
- ALU ops without forwarding:
  - ALUOp=10, funct=0x2A, data1=0xFFFFFFFF, data2=1 -> aluResult=1.
  - funct=0x2B with the same operands -> aluResult=0.
  - funct=0x03, shamt=4, data2=0x80000000 -> aluResult=0xF8000000.
- Forwarding priority: rs=5, exMemRd=5, memWbRd=5, both write enables set, exMemResult=0x11, memWbData=0x22, ALUOp=00, ALUSrc=1, immediate=1 -> aluResult=0x12.
  - Same with exMemRd=0 -> aluResult=0x23.
- mult, data1=0xFFFFFFFE (-2), data2=3 -> stall high exactly 33 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - A following mfhi returns 0xFFFFFFFF.
- divu 0x00000007 / 0 -> LO=0xFFFFFFFF, HI=7.
  - div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Reset asserted at BUSY cycle 10 of a multu (HI/LO previously 0x5/0x6) -> stall drops immediately, HI=LO=0.
  - After reset release with no mul/div in EX: stall stays 0.
- Branch and zero: cpPlus4=0x00000100, immediate=0xFFFFFFFF -> branchTarget=0x000000FC.
  - ALUOp=01 with equal operands -> zero=1.
